// File: rtl/pipe_stage_reg.sv
// Chained pipeline stage register with stall, flush and bubble clearing of the control field.
// Optional performance counters are enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Stall,
    input  logic                       Flush,
    input  logic                       In_Valid,
    input  logic [CTRL_W-1:0]          In_Ctrl,
    input  logic [DATA_W-1:0]          In_Data,
    output logic                       Out_Valid,
    output logic [CTRL_W-1:0]          Out_Ctrl,
    output logic [DATA_W-1:0]          Out_Data,
    output logic [$clog2(DEPTH+1)-1:0] Occ
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [15:0]                Stall_Cnt,
    output logic [15:0]                Flush_Cnt,
    output logic [15:0]                Kill_Cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be in 1..8");
    end

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + OCC_W'(v[k]);
        end
        return cnt;
    endfunction

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Stage next-state: Flush beats Stall beats advance; bubbles carry zero control.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (Flush) begin
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_d[k] = '0;
            end
        end else if (Stall) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
            data_d  = data_q;
        end else begin
            valid_d[0] = In_Valid;
            ctrl_d[0]  = In_Valid ? In_Ctrl : '0;
            data_d[0]  = In_Data;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
        occ_d = popcount(valid_d);
    end

    // Stage registers with synchronous reset of every field.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign Out_Valid = valid_q[DEPTH-1];
    assign Out_Ctrl  = ctrl_q[DEPTH-1];
    assign Out_Data  = data_q[DEPTH-1];
    assign Occ       = occ_q;

`ifdef PIPE_STAGE_REG_PERF_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] kill_cnt_q,  kill_cnt_d;

    // Saturating event counters; a flush kills whatever is currently occupied.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (Flush) begin
            flush_cnt_d = sat_add(flush_cnt_q, 16'd1);
            kill_cnt_d  = sat_add(kill_cnt_q, {{(16-OCC_W){1'b0}}, occ_q});
        end else if (Stall) begin
            stall_cnt_d = sat_add(stall_cnt_q, 16'd1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            kill_cnt_q  <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
    assign Kill_Cnt  = kill_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8: control-field width (memory and writeback controls, bubble-cleared).
REQ-002 SHALL have parameter DATA_W, default 32: data-field width (PC values, ALU result, operands, destination register).
REQ-003 SHALL have parameter DEPTH, default 1: number of chained register stages; legal range 1..8; any other value SHALL fail elaboration.
REQ-004 SHALL have port Clk  input  1  rising-edge clock.
REQ-005 SHALL have port Rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port Stall  input  1  freeze all stages.
REQ-007 SHALL have port Flush  input  1  kill all in-flight entries.
REQ-008 SHALL have port In_Valid  input  1  stage-0 input carries a real instruction.
REQ-009 SHALL have port In_Ctrl  input  CTRL_W  incoming control field.
REQ-010 SHALL have port In_Data  input  DATA_W  incoming data field.
REQ-011 SHALL have port Out_Valid  output  1  last-stage valid.
REQ-012 SHALL have port Out_Ctrl  output  CTRL_W  last-stage control.
REQ-013 SHALL have port Out_Data  output  DATA_W  last-stage data.
REQ-014 SHALL have port Occ  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-015 Each stage k SHALL hold registers valid[k], ctrl[k] and data[k]; outputs SHALL be driven directly from stage DEPTH-1 registers.
REQ-016 Edge priority SHALL be Rst > Flush > Stall > advance.
REQ-017 Advance: stage 0 <- inputs and stage k <- stage k-1; latency In->Out SHALL be exactly DEPTH edges with no stall.
REQ-018 When In_Valid=0 on advance, stage 0 SHALL capture valid=0 and ctrl=0 (bubble); data SHALL capture In_Data unchanged.
REQ-019 When Stall=1 (Flush=0), every stage SHALL hold valid, ctrl and data unchanged, and inputs SHALL be ignored.
REQ-020 When Flush=1, every stage SHALL get valid=0 and ctrl=0 on that edge, data SHALL hold, inputs SHALL be discarded, and Stall SHALL be ignored.
REQ-021 Occ SHALL equal the popcount of valid[0..DEPTH-1] in the same cycle, ranging 0..DEPTH with no wrap.
REQ-022 An invalid output SHALL always present Out_Ctrl=0, so a downstream write or branch can never fire from a bubble.

Reset
REQ-023 On Rst=1 at a rising edge, every valid, ctrl and data register of every stage SHALL become 0, with no field left unreset.
REQ-024 Rst SHALL override a concurrent Stall or Flush; the first edge after Rst deasserts SHALL behave as a normal advance.

Configuration
REQ-025 Macro PIPE_STAGE_REG_PERF_EN, when defined, SHALL add outputs Stall_Cnt, Flush_Cnt and Kill_Cnt, each 16 bits, reset to 0 by Rst.
REQ-026 With the macro defined, counters SHALL behave as follows:
- Stall_Cnt +1 per edge with Stall=1 and Flush=0.
- Flush_Cnt +1 per edge with Flush=1.
- Kill_Cnt += Occ at each flush edge.
- All counters saturate at 0xFFFF; no wrap.
REQ-027 Without the macro, these ports and registers SHALL be absent, and the remaining behaviour SHALL be identical.

Verification (DEPTH=3, CTRL_W=8, DATA_W=32)
REQ-028 Stream: after reset, drive In_Valid=1 with In_Data 0x11, 0x22, 0x33 and In_Ctrl 0xA1, 0xA2, 0xA3 on three edges -> after edge 3, Out_Data=0x11, Out_Ctrl=0xA1, Out_Valid=1, Occ=3.
REQ-029 Stall: with the pipe full, hold Stall=1 for 2 edges while In_Data=0x99 -> outputs unchanged (0x11/0xA1), Occ=3, Stall_Cnt=2; on the next advance Out_Data=0x22.
REQ-030 Flush: with Occ=3, pulse Flush for one edge -> Out_Valid=0, Out_Ctrl=0, Out_Data held, Occ=0, Flush_Cnt=1, Kill_Cnt=3.
REQ-031 Flush+Stall on the same edge -> identical to REQ-030, Stall_Cnt unchanged.
REQ-032 Bubble: insert In_Valid=0 with In_Ctrl=0xFF between valid entries -> after 3 edges, Out_Valid=0 and Out_Ctrl=0x00.
REQ-033 Reset mid-stream: assert Rst with Stall=1 and Flush=1 -> all outputs 0 and Occ=0 next cycle; with Stall_Cnt preset to 0xFFFF, a further stall edge keeps it at 0xFFFF.
